// File: rtl/mdio_arb_pkg.sv
// Shared types and constants for the MDIO requester arbiter.
// State encoding and MDIO field widths.
package mdio_arb_pkg;

    localparam int MDIO_ADDR_W = 5;
    localparam int MDIO_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set-bit finder: searches pend upward from ptr,
// wrapping at N. Purely combinational.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    int idx;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (pend[idx]) begin
                grant = PW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdio_req_arbiter.sv
// Shares one MDIO master port between NUM_REQ requesters with
// round-robin grants and a per-transaction timeout.
module mdio_req_arbiter
    import mdio_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_request,
    input  logic [NUM_REQ-1:0]             i_req_rdwn,
    input  logic [MDIO_ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [MDIO_DATA_W*NUM_REQ-1:0] i_req_wr_data,
    output logic [NUM_REQ-1:0]             o_req_done,
    output logic [NUM_REQ-1:0]             o_req_err,
    output logic [MDIO_DATA_W-1:0]         o_req_rd_data,
    output logic [NUM_REQ-1:0]             o_req_overrun,
    output logic                           o_phy_request,
    output logic                           o_phy_rdwn,
    output logic [MDIO_ADDR_W-1:0]         o_phy_addr,
    output logic [MDIO_DATA_W-1:0]         o_phy_wr_data,
    input  logic                           i_phy_done,
    input  logic [MDIO_DATA_W-1:0]         i_phy_rd_data,
    output logic                           o_busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state;
    logic [NUM_REQ-1:0]     pend;
    logic [NUM_REQ-1:0]     slot_fin;
    logic [NUM_REQ-1:0]     slot_rdwn;
    logic [MDIO_ADDR_W-1:0] slot_addr  [NUM_REQ];
    logic [MDIO_DATA_W-1:0] slot_wdata [NUM_REQ];
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          gnt;
    logic [PW-1:0]          pick;
    logic                   pick_vld;
    logic [TO_W-1:0]        to_cnt;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .pend  (pend),
        .ptr   (ptr),
        .grant (pick),
        .valid (pick_vld)
    );

    // A slot being retired this cycle may accept a fresh request.
    always_comb begin
        slot_fin = '0;
        if (state == ST_DONE) slot_fin[gnt] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend          <= '0;
            slot_rdwn     <= '0;
            o_req_overrun <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                slot_addr[k]  <= '0;
                slot_wdata[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                o_req_overrun[k] <= 1'b0;
                if (i_req_request[k] && (!pend[k] || slot_fin[k])) begin
                    pend[k]       <= 1'b1;
                    slot_rdwn[k]  <= i_req_rdwn[k];
                    slot_addr[k]  <= i_req_addr[MDIO_ADDR_W*k +: MDIO_ADDR_W];
                    slot_wdata[k] <= i_req_wr_data[MDIO_DATA_W*k +: MDIO_DATA_W];
                end else if (i_req_request[k]) begin
                    o_req_overrun[k] <= 1'b1;
                end else if (slot_fin[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            gnt           <= '0;
            to_cnt        <= '0;
            o_req_done    <= '0;
            o_req_err     <= '0;
            o_req_rd_data <= '0;
            o_phy_request <= 1'b0;
            o_phy_rdwn    <= 1'b0;
            o_phy_addr    <= '0;
            o_phy_wr_data <= '0;
            o_busy        <= 1'b0;
        end else begin
            o_phy_request <= 1'b0;
            o_req_done    <= '0;
            o_req_err     <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt           <= pick;
                        o_phy_request <= 1'b1;
                        o_phy_rdwn    <= slot_rdwn[pick];
                        o_phy_addr    <= slot_addr[pick];
                        o_phy_wr_data <= slot_wdata[pick];
                        o_busy        <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_phy_done) begin
                        o_req_rd_data   <= i_phy_rd_data;
                        o_req_done[gnt] <= 1'b1;
                        state           <= ST_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        o_req_rd_data   <= '0;
                        o_req_done[gnt] <= 1'b1;
                        o_req_err[gnt]  <= 1'b1;
                        state           <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ptr           <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
                    o_req_rd_data <= '0;
                    o_phy_rdwn    <= 1'b0;
                    o_phy_addr    <= '0;
                    o_phy_wr_data <= '0;
                    o_busy        <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_req_arbiter.sv
// Scoreboard bench for mdio_req_arbiter: expected PHY issues and
// requester completions are queued by stimulus, popped by a monitor.
module tb_mdio_req_arbiter;

    localparam int N  = 3;
    localparam int T  = 20;
    localparam int TW = 5;

    typedef struct {
        logic        rdwn;
        logic [4:0]  addr;
        logic [31:0] wd;
    } iss_t;

    typedef struct {
        logic [2:0]  done;
        logic [2:0]  err;
        logic [31:0] rd;
    } cmp_t;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [N-1:0]  req;
    logic [N-1:0]  rdwn;
    logic [5*N-1:0]  addr;
    logic [32*N-1:0] wdata;
    logic [N-1:0]  o_req_done;
    logic [N-1:0]  o_req_err;
    logic [31:0]   o_req_rd_data;
    logic [N-1:0]  o_req_overrun;
    logic          o_phy_request;
    logic          o_phy_rdwn;
    logic [4:0]    o_phy_addr;
    logic [31:0]   o_phy_wr_data;
    logic          i_phy_done;
    logic [31:0]   i_phy_rd_data;
    logic          o_busy;

    iss_t       exp_iss[$];
    cmp_t       exp_cmp[$];
    logic [2:0] exp_ovr[$];
    int         iss_log[$];
    int         done_log[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cyc = 0;
    int phy_done_cyc = -10;
    int phy_delay = 5;
    int mute = 0;
    int pcnt = 0;
    bit stray = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] phy_mem [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdio_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T),
        .TO_W           (TW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_req_request (req),
        .i_req_rdwn    (rdwn),
        .i_req_addr    (addr),
        .i_req_wr_data (wdata),
        .o_req_done    (o_req_done),
        .o_req_err     (o_req_err),
        .o_req_rd_data (o_req_rd_data),
        .o_req_overrun (o_req_overrun),
        .o_phy_request (o_phy_request),
        .o_phy_rdwn    (o_phy_rdwn),
        .o_phy_addr    (o_phy_addr),
        .o_phy_wr_data (o_phy_wr_data),
        .i_phy_done    (i_phy_done),
        .i_phy_rd_data (i_phy_rd_data),
        .o_busy        (o_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic slot(input int k, input logic rd,
                        input logic [4:0] a, input logic [31:0] d);
        rdwn[k]         = rd;
        addr[5*k +: 5]  = a;
        wdata[32*k +: 32] = d;
    endtask

    task automatic fire(input logic [2:0] m);
        @(negedge clk);
        req     = m;
        req_cyc = cyc;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_iss.size() == 0 && exp_cmp.size() == 0 && !o_busy)
                break;
        end
        if (n == 400) chk("idle_tmo", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic hold_chk();
        int n;
        bit ok;
        ok = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_phy_request) break;
        end
        if (n == 50) chk("wr_issue_tmo", 64'd1, 64'd0);
        for (n = 0; n < 50; n++) begin
            if (o_phy_rdwn !== 1'b0 || o_phy_addr !== 5'h00 ||
                o_phy_wr_data !== 32'h1140)
                ok = 1'b0;
            if (o_req_done[2]) break;
            @(negedge clk);
        end
        chk("wr_hold", 64'(ok), 64'd1);
        @(negedge clk);
        chk("wr_idle_clr", 64'({o_phy_addr, o_phy_wr_data}), 64'd0);
    endtask

    // PHY model: answers each issue after phy_delay cycles unless muted.
    initial begin
        i_phy_done    = 1'b0;
        i_phy_rd_data = '0;
        forever begin
            @(negedge clk);
            i_phy_done    = 1'b0;
            i_phy_rd_data = '0;
            if (stray) begin
                i_phy_done    = 1'b1;
                i_phy_rd_data = 32'hDEAD_BEEF;
                stray         = 1'b0;
            end
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0) begin
                    i_phy_done    = 1'b1;
                    i_phy_rd_data = phy_mem[paddr];
                    phy_done_cyc  = cyc;
                end
            end
            if (o_phy_request) begin
                if (mute > 0) mute--;
                else begin
                    pcnt  = phy_delay;
                    paddr = o_phy_addr;
                end
            end
        end
    end

    initial begin : mon
        iss_t e;
        cmp_t c;
        logic [2:0] o;
        forever begin
            @(negedge clk);
            if (o_phy_request === 1'b1) begin
                iss_log.push_back(cyc);
                if (exp_iss.size() == 0) chk("unexp_issue", 64'd1, 64'd0);
                else begin
                    e = exp_iss.pop_front();
                    chk("issue", 64'({o_phy_rdwn, o_phy_addr, o_phy_wr_data}),
                        64'({e.rdwn, e.addr, e.wd}));
                end
            end
            if (o_req_done != 0 || o_req_err != 0) begin
                done_log.push_back(cyc);
                if (exp_cmp.size() == 0)
                    chk("unexp_done", 64'({o_req_done, o_req_err}), 64'd0);
                else begin
                    c = exp_cmp.pop_front();
                    chk("done", 64'({o_req_done, o_req_err, o_req_rd_data}),
                        64'({c.done, c.err, c.rd}));
                    if (c.err == 3'b000)
                        chk("done_lat", 64'(cyc - phy_done_cyc), 64'd1);
                end
            end
            if (o_req_overrun != 0) begin
                if (exp_ovr.size() == 0)
                    chk("unexp_ovr", 64'(o_req_overrun), 64'd0);
                else begin
                    o = exp_ovr.pop_front();
                    chk("overrun", 64'(o_req_overrun), 64'(o));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int i0;
        int d0;
        int n;
        int q;
        bit seen;
        i_rst = 1'b1;
        req   = '0;
        rdwn  = '0;
        addr  = '0;
        wdata = '0;
        for (int k = 0; k < 32; k++) phy_mem[k] = '0;
        phy_mem[5'h01] = 32'h0000_796D;
        phy_mem[5'h02] = 32'h0000_0C01;
        phy_mem[5'h03] = 32'h0123_4567;
        phy_mem[5'h06] = 32'h0000_0066;
        phy_mem[5'h07] = 32'h0000_0077;
        phy_mem[5'h11] = 32'h0000_8000;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_phy", 64'({o_phy_request, o_phy_rdwn, o_phy_addr,
                            o_phy_wr_data}), 64'd0);
        chk("rst_req", 64'({o_req_done, o_req_err, o_req_overrun, o_busy}),
            64'd0);
        chk("rst_rd", 64'(o_req_rd_data), 64'd0);

        // single read from requester 1
        slot(1, 1'b1, 5'h11, 32'h0);
        exp_iss.push_back('{1'b1, 5'h11, 32'h0});
        exp_cmp.push_back('{3'b010, 3'b000, 32'h0000_8000});
        i0 = iss_log.size();
        fire(3'b010);
        wait_idle();
        chk("rd_lat", 64'(iss_log[i0] - req_cyc), 64'd2);

        // write from requester 2, fields held ISSUE..DONE
        slot(2, 1'b0, 5'h00, 32'h0000_1140);
        exp_iss.push_back('{1'b0, 5'h00, 32'h0000_1140});
        exp_cmp.push_back('{3'b100, 3'b000, 32'h0});
        fork
            fire(3'b100);
            hold_chk();
        join
        wait_idle();

        // two rounds of simultaneous requests, ptr back at 0
        for (int r = 0; r < 2; r++) begin
            slot(0, 1'b1, 5'h01, 32'h0);
            slot(1, 1'b1, 5'h02, 32'h0);
            slot(2, 1'b1, 5'h03, 32'h0);
            exp_iss.push_back('{1'b1, 5'h01, 32'h0});
            exp_iss.push_back('{1'b1, 5'h02, 32'h0});
            exp_iss.push_back('{1'b1, 5'h03, 32'h0});
            exp_cmp.push_back('{3'b001, 3'b000, 32'h0000_796D});
            exp_cmp.push_back('{3'b010, 3'b000, 32'h0000_0C01});
            exp_cmp.push_back('{3'b100, 3'b000, 32'h0123_4567});
            i0 = iss_log.size();
            fire(3'b111);
            wait_idle();
            chk("rr_gap01", 64'(iss_log[i0+1] - iss_log[i0]), 64'd8);
            chk("rr_gap12", 64'(iss_log[i0+2] - iss_log[i0+1]), 64'd8);
        end

        // timeout on requester 0, then requester 1 granted
        mute = 1;
        slot(0, 1'b1, 5'h05, 32'h0);
        slot(1, 1'b1, 5'h02, 32'h0);
        exp_iss.push_back('{1'b1, 5'h05, 32'h0});
        exp_iss.push_back('{1'b1, 5'h02, 32'h0});
        exp_cmp.push_back('{3'b001, 3'b001, 32'h0});
        exp_cmp.push_back('{3'b010, 3'b000, 32'h0000_0C01});
        i0 = iss_log.size();
        d0 = done_log.size();
        fire(3'b011);
        wait_idle();
        chk("to_lat", 64'(done_log[d0] - iss_log[i0]), 64'(T + 1));
        chk("to_next", 64'(iss_log[i0+1] - done_log[d0]), 64'd2);

        // overrun: second pulse while pending is dropped
        slot(0, 1'b0, 5'h09, 32'h0000_ABCD);
        exp_iss.push_back('{1'b0, 5'h09, 32'h0000_ABCD});
        exp_cmp.push_back('{3'b001, 3'b000, 32'h0});
        exp_ovr.push_back(3'b001);
        fire(3'b001);
        fire(3'b001);
        wait_idle();

        // re-request in own DONE cycle is accepted
        slot(0, 1'b1, 5'h06, 32'h0);
        exp_iss.push_back('{1'b1, 5'h06, 32'h0});
        exp_iss.push_back('{1'b1, 5'h07, 32'h0});
        exp_cmp.push_back('{3'b001, 3'b000, 32'h0000_0066});
        exp_cmp.push_back('{3'b001, 3'b000, 32'h0000_0077});
        fire(3'b001);
        slot(0, 1'b1, 5'h07, 32'h0);
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_req_done[0]) begin
                req  = 3'b001;
                seen = 1'b1;
                @(negedge clk);
                req = '0;
                break;
            end
        end
        chk("redo_seen", 64'(seen), 64'd1);
        wait_idle();

        // reset while waiting on the PHY
        mute = 1;
        slot(2, 1'b1, 5'h1F, 32'h0);
        exp_iss.push_back('{1'b1, 5'h1F, 32'h0});
        fire(3'b100);
        for (n = 0; n < 50; n++) begin
            if (o_phy_request) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("rst_mid", 64'({o_phy_request, o_phy_rdwn, o_phy_addr,
                            o_req_done, o_req_err, o_busy}), 64'd0);
        stray = 1'b1;
        q = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_busy || o_phy_request || o_req_done != 0) q++;
        end
        chk("rst_quiet", 64'(q), 64'd0);

        // ptr cleared by reset: 0 is served before 2
        mute = 0;
        slot(0, 1'b1, 5'h01, 32'h0);
        slot(2, 1'b1, 5'h03, 32'h0);
        exp_iss.push_back('{1'b1, 5'h01, 32'h0});
        exp_iss.push_back('{1'b1, 5'h03, 32'h0});
        exp_cmp.push_back('{3'b001, 3'b000, 32'h0000_796D});
        exp_cmp.push_back('{3'b100, 3'b000, 32'h0123_4567});
        fire(3'b101);
        wait_idle();

        chk("leftover", 64'(exp_iss.size() + exp_cmp.size() + exp_ovr.size()),
            64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdio_req_arbiter.md
Name: mdio_req_arbiter

Overview:
- Shares the single PHY management (MDIO) master port between NUM_REQ independent requesters, e.g. the link-speed poller, host register bridge and PHY init sequencer.
- Each requester issues a one-cycle request pulse with address, direction and write data, then waits for a one-cycle done pulse.
- The block latches pending requests, grants round-robin, serialises transactions onto the PHY port and guards each one with a timeout.
- It sits between the requesters and the MDIO master, in the gmac management clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, cycles in WAIT before a transaction is aborted (>=2).
- TO_W, 13, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_request  in  NUM_REQ  per-requester request pulse (1 cycle).
- i_req_rdwn  in  NUM_REQ  per-requester 1=read, 0=write; sampled with request.
- i_req_addr  in  5*NUM_REQ  per-requester PHY register address; slice k = [5k+4:5k].
- i_req_wr_data  in  32*NUM_REQ  per-requester write data; slice k = [32k+31:32k].
- o_req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- o_req_err  out  NUM_REQ  pulses together with o_req_done when the transaction timed out.
- o_req_rd_data  out  32  shared read data; valid only in the o_req_done cycle.
- o_req_overrun  out  NUM_REQ  one-cycle pulse when a request arrives while that slot is already pending (request dropped).
- o_phy_request  out  1  one-cycle request pulse to the MDIO master.
- o_phy_rdwn  out  1  direction to the MDIO master.
- o_phy_addr  out  5  register address to the MDIO master.
- o_phy_wr_data  out  32  write data to the MDIO master.
- i_phy_done  in  1  MDIO master completion pulse.
- i_phy_rd_data  in  32  MDIO read data; valid with i_phy_done.
- o_busy  out  1  high while in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset also clears all pend bits, the RR pointer (to 0), the grant and the timeout counter.
- Request capture, per slot k: i_req_request[k] with pend[k]=0 stores rdwn/addr/wr_data into slot k and sets pend[k] on the next edge.
  - If pend[k]=1 and the slot is not completing this cycle, the request is dropped and o_req_overrun[k] pulses the next cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any pend bit is set, the grant g is the first set bit searching from ptr upward with wrap. Load o_phy_rdwn/addr/wr_data from slot g, set o_phy_request=1, go to ISSUE.
- ISSUE (1 cycle): o_phy_request is high during this cycle. Drop it to 0, clear the counter, go to WAIT.
- WAIT: counter increments each cycle.
  - i_phy_done=1: capture i_phy_rd_data into o_req_rd_data, err=0, go to DONE.
  - Otherwise, counter==TIMEOUT_CYCLES-1: o_req_rd_data=0, err=1, go to DONE.
  - If i_phy_done and timeout coincide, done wins (err=0).
- DONE (1 cycle): o_req_done[g]=1 and o_req_err[g]=err this cycle. Clear pend[g], set ptr=(g+1) mod NUM_REQ, go to IDLE.
- o_phy_addr/rdwn/wr_data hold their values from ISSUE through DONE and return to 0 in IDLE.
- i_phy_done outside WAIT is ignored.
- Latency:
  - Request pulse in cycle 0 with arbiter idle and no other pending: o_phy_request high in cycle 2.
  - i_phy_done in cycle n: o_req_done high in cycle n+1.
  - Back-to-back grants: one IDLE cycle between DONE and the next ISSUE.
- Simultaneous events:
  - Requester g pulses a new request in its own DONE cycle: the new request is accepted (pend stays 1, slot reloaded), no overrun.
  - Several requests in one cycle: all captured; service order is RR from ptr.
- Reset mid-transaction: aborts immediately. No done or err is delivered, and o_phy_request is low the cycle after reset.

Decomposition:
- Shared package mdio_arb_pkg holds:
  - the state encoding constants (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - MDIO_ADDR_W=5 and MDIO_DATA_W=32.
- Sub-module rr_pick: combinational round-robin first-set-bit finder (inputs pend and ptr, outputs grant index and a valid flag). It is reusable by the MAC register-bus arbiter.

Test Plan:
- Single read: req1 pulse, addr=0x11, rdwn=1; PHY returns 0x0000_8000 done 5 cycles after o_phy_request -> o_phy_request in cycle 2 with addr 0x11; o_req_done[1] and o_req_rd_data=0x0000_8000 one cycle after i_phy_done; o_req_err=0.
- Simultaneous requests from 0, 1 and 2 in one cycle, ptr=0 -> served in order 0,1,2. A repeat of all three afterwards is served 0,1,2 again (ptr wraps), with exactly one IDLE cycle between transactions.
- Write: req2 writes addr=0x00, data=0x0000_1140 -> o_phy_rdwn=0 and o_phy_wr_data=0x0000_1140 held from ISSUE through DONE; o_req_done[2] pulses.
- Timeout: PHY never asserts done -> o_req_done[0] and o_req_err[0] exactly TIMEOUT_CYCLES cycles after the ISSUE cycle's successor; o_req_rd_data=0; next pending requester then granted.
- Overrun and same-cycle re-request:
  - req0 pulses twice while pending -> o_req_overrun[0] pulses once, one transaction only.
  - req0 pulse in its own DONE cycle -> a second transaction issues, no overrun.
- Reset in WAIT: assert i_rst for 1 cycle -> no o_req_done, all outputs 0, pend cleared, and a stray i_phy_done afterwards is ignored.
